dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter: ADDR_W, 32, width of addrM and mem_addr.
REQ-002 Parameter: DATA_W, 32, data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 memreadM  input  1  M-stage load request.
REQ-006 memwriteM  input  1  M-stage store request.
REQ-007 sizeM  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 unsignedM  input  1  1 = zero-extend load, 0 = sign-extend load.
REQ-009 addrM  input  ADDR_W  byte address (ALU output in M).
REQ-010 wdataM  input  32  store data (write data in M).
REQ-011 readdataM  output  32  formatted load data to the M/W register.
REQ-012 stallM  output  1  holds every pipeline stage while high.
REQ-013 misalignM  output  1  one-cycle misaligned-access flag.
REQ-014 mem_req  output  1  memory request, registered.
REQ-015 mem_we  output  1  1 = write.
REQ-016 mem_addr  output  ADDR_W  word-aligned address; bits [1:0] are 00.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_wstrb  output  4  byte enables; 0000 on reads.
REQ-019 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-020 mem_rdata  input  32  read word, valid together with mem_ack.

Function
REQ-021 FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY on a valid access.
- BUSY to DONE on mem_ack.
- DONE to IDLE unconditionally.
REQ-022 stallM = (memreadM|memwriteM) & ~misaligned & (state!=DONE), combinational.
REQ-023 On IDLE to BUSY, the block registers mem_req=1, mem_we, mem_addr, mem_wdata and mem_wstrb, and holds them stable until the cycle after mem_ack.
REQ-024 mem_req drops on the edge that enters DONE; mem_ack outside BUSY is ignored.
REQ-025 Minimum access is 2 stall cycles (ack in the first BUSY cycle); each extra wait cycle adds one stall cycle.
REQ-026 When memreadM and memwriteM are both high, the access is a write.
REQ-027 Load: the byte lane is selected by addr[1:0] and the half lane by addr[1]; the result is sign- or zero-extended per unsignedM and captured into the readdataM register on mem_ack.
REQ-028 readdataM holds its value until the next load completes.
REQ-029 Store byte: wdata = {4{wdataM[7:0]}}, wstrb = 0001 shifted left by addr[1:0].
REQ-030 Store half: wdata = {2{wdataM[15:0]}}, wstrb = 0011 if addr[1]=0, else 1100.
REQ-031 Store word: wdata = wdataM, wstrb = 1111.
REQ-032 With no request in IDLE, all mem_* outputs are 0 and stallM is 0.

Reset
REQ-033 On rst, next edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, readdataM=0, misalignM=0.
REQ-034 rst asserted during BUSY abandons the access; a mem_ack arriving after reset is ignored.

Configuration
REQ-035 Macro DMEM_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, issues no memory request, keeps stallM low, pulses misalignM for one cycle, and leaves readdataM unchanged.
- Undefined: misalignM is tied to 0 and the low address bits only select lanes.

Structure
REQ-036 Package lsu_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-037 One sub-module, load_align, performs combinational lane extraction and extension.

Verification
REQ-038 Word load at addr 0x10, ack in first BUSY cycle, rdata 0xDEADBEEF -> stallM high 2 cycles, readdataM=0xDEADBEEF.
REQ-039 Signed byte load at addr 0x13, rdata 0x80112233 -> readdataM=0xFFFFFF80; same access unsigned -> readdataM=0x00000080.
REQ-040 Half store at addr 0x22, wdataM=0x0000ABCD -> mem_addr=0x20, mem_wdata=0xABCDABCD, mem_wstrb=1100, mem_we=1.
REQ-041 Load with ack delayed 5 cycles -> stallM high 6 cycles; mem_req and mem_addr stable throughout.
REQ-042 DMEM_ALIGN_CHECK_EN defined, word load at addr 0x06 -> mem_req stays 0, misalignM=1 for one cycle, stallM=0.
REQ-043 rst during BUSY, then stray mem_ack -> state IDLE, readdataM=0, no DONE cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   SZ_*      : sizeM access-size encodings (2'b11 behaves as a word)
//   state_t   : load/store unit FSM states
//   store_*() : store lane replication and byte-enable generation
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Replicate the store operand across every lane it may land in.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Byte enables for the lanes actually written.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction and sign/zero extension (combinational).
//   rdata  : raw 32-bit word from memory
//   off    : byte offset of the access within the word
//   size   : access size (lsu_pkg SZ_* encoding)
//   zext   : 1 = zero-extend, 0 = sign-extend
//   data_c : formatted load result
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane from off[1:0], half lane from off[1].
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_c = rdata;
        case (size)
            SZ_BYTE: data_c = {{24{~zext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_c = {{16{~zext & half_sel[15]}}, half_sel};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// M-stage data-memory load/store unit: issues one registered memory request
// per access, stalls the pipeline until the access completes, formats loads.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses are
// dropped and flagged on misalignM instead of being issued.
//   clk, rst            : clock, synchronous active-high reset
//   memreadM/memwriteM  : load/store request (write wins if both)
//   sizeM, unsignedM    : access size, load extension mode
//   addrM, wdataM       : byte address, store data
//   readdataM           : registered load result, updated on load completion
//   stallM              : combinational pipeline hold
//   misalignM           : one-cycle misaligned-access flag
//   mem_*               : registered memory request, completed by mem_ack
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [1:0]        sizeM,
    input  logic              unsignedM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [DATA_W-1:0] wdataM,
    output logic [DATA_W-1:0] readdataM,
    output logic              stallM,
    output logic              misalignM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             state, state_nxt;
    logic               req_nxt, we_nxt, mis_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt, rdata_nxt;
    logic [3:0]         wstrb_nxt;
    logic [1:0]         ld_off, ld_off_nxt, ld_size, ld_size_nxt;
    logic               ld_zext, ld_zext_nxt;
    logic               misaligned_c, access_c;
    logic [DATA_W-1:0]  align_data_c;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned_c = (memreadM | memwriteM) &
                          (((sizeM == SZ_HALF) & addrM[0]) | (sizeM[1] & (addrM[1:0] != 2'b00)));
`else
    assign misaligned_c = 1'b0;
`endif

    assign access_c = (memreadM | memwriteM) & ~misaligned_c;
    assign stallM   = access_c & (state != ST_DONE);

    // Load formatting uses the offset/size captured at issue.
    load_align u_load_align (
        .rdata  (mem_rdata),
        .off    (ld_off),
        .size   (ld_size),
        .zext   (ld_zext),
        .data_c (align_data_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt   = state;
        req_nxt     = mem_req;
        we_nxt      = mem_we;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        wstrb_nxt   = mem_wstrb;
        rdata_nxt   = readdataM;
        ld_off_nxt  = ld_off;
        ld_size_nxt = ld_size;
        ld_zext_nxt = ld_zext;
        mis_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                mis_nxt = misaligned_c;
                if (access_c) begin
                    state_nxt   = ST_BUSY;
                    req_nxt     = 1'b1;
                    we_nxt      = memwriteM;
                    addr_nxt    = {addrM[ADDR_W-1:2], 2'b00};
                    wdata_nxt   = memwriteM ? store_data(sizeM, wdataM) : '0;
                    wstrb_nxt   = memwriteM ? store_strb(sizeM, addrM[1:0]) : 4'b0000;
                    ld_off_nxt  = addrM[1:0];
                    ld_size_nxt = sizeM;
                    ld_zext_nxt = unsignedM;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_nxt = ST_DONE;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    addr_nxt  = '0;
                    wdata_nxt = '0;
                    wstrb_nxt = 4'b0000;
                    if (!mem_we) begin
                        rdata_nxt = align_data_c;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            readdataM <= '0;
            misalignM <= 1'b0;
            ld_off    <= 2'b00;
            ld_size   <= 2'b00;
            ld_zext   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_wstrb <= wstrb_nxt;
            readdataM <= rdata_nxt;
            misalignM <= mis_nxt;
            ld_off    <= ld_off_nxt;
            ld_size   <= ld_size_nxt;
            ld_zext   <= ld_zext_nxt;
        end
    end

endmodule
